// File: rtl/parking_keypad_entry.sv
// Purpose: two-digit parking keypad entry FSM that submits a code to the parking controller,
//          with a response window, a consecutive-failure lockout and an inactivity timeout.
// Latency: one cycle from a key strobe to the registered state/output update.
// Backpressure: none; keys that arrive in a state that cannot use them are dropped.
//
// Ports:
//   clk, reset (async, active-high)
//   key_code[3:0], key_valid, key_enter, key_clear : keypad strobes
//   entry_gate_open, lot_full                      : parking controller status
//   passcode_in[7:0], enter_req                    : submission to the parking controller
//   digit_count[1:0], fail_count[1:0], locked_out, busy : status
module parking_keypad_entry #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int RESP_WINDOW    = 8,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    input  logic       key_enter,
    input  logic       key_clear,
    input  logic       entry_gate_open,
    input  logic       lot_full,
    output logic [7:0] passcode_in,
    output logic       enter_req,
    output logic [1:0] digit_count,
    output logic [1:0] fail_count,
    output logic       locked_out,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(RESP_WINDOW + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RESP_LAST  = RW'(RESP_WINDOW - 1);
    localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0]    FAIL_MAX   = 2'(MAX_FAILS);

    typedef enum logic [2:0] {
        IDLE,
        DIGIT1,
        READY,
        REQ,
        WAIT_RESP,
        LOCKOUT
    } state_t;

    state_t        state;
    logic [7:0]    passcode;
    logic [TW-1:0] idle_timer;
    logic [RW-1:0] resp_cnt;
    logic [LW-1:0] lock_cnt;
    logic [1:0]    fail_inc;

    // Saturating increment: fail_count never exceeds MAX_FAILS.
    assign fail_inc = (fail_count >= FAIL_MAX) ? FAIL_MAX : fail_count + 2'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            passcode    <= 8'h00;
            idle_timer  <= '0;
            resp_cnt    <= '0;
            lock_cnt    <= '0;
            passcode_in <= 8'h00;
            enter_req   <= 1'b0;
            digit_count <= 2'd0;
            fail_count  <= 2'd0;
            locked_out  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            enter_req <= 1'b0;
            case (state)
                // Clear and enter have no meaning here, but they still outrank
                // a same-cycle digit, which is then dropped.
                IDLE: begin
                    if (!key_clear && !key_enter && key_valid) begin
                        passcode    <= {key_code, 4'h0};
                        digit_count <= 2'd1;
                        idle_timer  <= '0;
                        state       <= DIGIT1;
                    end
                end

                DIGIT1: begin
                    if (key_clear) begin
                        digit_count <= 2'd0;
                        state       <= IDLE;
                    end else if (!key_enter && key_valid) begin
                        passcode[3:0] <= key_code;
                        digit_count   <= 2'd2;
                        idle_timer    <= '0;
                        state         <= READY;
                    end else if (idle_timer == TIMER_LAST) begin
                        digit_count <= 2'd0;
                        state       <= IDLE;
                    end else begin
                        idle_timer <= idle_timer + 1'b1;
                    end
                end

                READY: begin
                    if (key_clear) begin
                        digit_count <= 2'd0;
                        state       <= IDLE;
                    end else if (key_enter) begin
                        if (lot_full) begin
                            digit_count <= 2'd0;
                            state       <= IDLE;
                        end else begin
                            // Outputs registered on entry so they line up with REQ.
                            enter_req   <= 1'b1;
                            busy        <= 1'b1;
                            passcode_in <= passcode;
                            state       <= REQ;
                        end
                    end else if (idle_timer == TIMER_LAST) begin
                        digit_count <= 2'd0;
                        state       <= IDLE;
                    end else begin
                        idle_timer <= idle_timer + 1'b1;
                    end
                end

                REQ: begin
                    resp_cnt <= '0;
                    state    <= WAIT_RESP;
                end

                WAIT_RESP: begin
                    if (entry_gate_open) begin
                        fail_count  <= 2'd0;
                        digit_count <= 2'd0;
                        busy        <= 1'b0;
                        passcode_in <= 8'h00;
                        state       <= IDLE;
                    end else if (resp_cnt == RESP_LAST) begin
                        fail_count  <= fail_inc;
                        digit_count <= 2'd0;
                        busy        <= 1'b0;
                        passcode_in <= 8'h00;
                        if (fail_inc == FAIL_MAX) begin
                            locked_out <= 1'b1;
                            lock_cnt   <= '0;
                            state      <= LOCKOUT;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        resp_cnt <= resp_cnt + 1'b1;
                    end
                end

                LOCKOUT: begin
                    if (lock_cnt == LOCK_LAST) begin
                        locked_out <= 1'b0;
                        fail_count <= 2'd0;
                        state      <= IDLE;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parking_keypad_entry.sv
// Purpose: directed self-checking bench for parking_keypad_entry.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; the controller response is driven by the stimulus.
module tb_parking_keypad_entry;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       key_valid = 1'b0;
    logic       key_enter = 1'b0;
    logic       key_clear = 1'b0;
    logic       entry_gate_open = 1'b0;
    logic       lot_full = 1'b0;
    logic [7:0] passcode_in;
    logic       enter_req;
    logic [1:0] digit_count;
    logic [1:0] fail_count;
    logic       locked_out;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int base;

    parking_keypad_entry dut (
        .clk             (clk),
        .reset           (reset),
        .key_code        (key_code),
        .key_valid       (key_valid),
        .key_enter       (key_enter),
        .key_clear       (key_clear),
        .entry_gate_open (entry_gate_open),
        .lot_full        (lot_full),
        .passcode_in     (passcode_in),
        .enter_req       (enter_req),
        .digit_count     (digit_count),
        .fail_count      (fail_count),
        .locked_out      (locked_out),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Counts cycles in which enter_req was high.
    always @(posedge clk) if (enter_req) pulses++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic digit(input logic [3:0] k);
        key_code  = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic enter();
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pass"},   32'(passcode_in), 32'h00);
        chk({tag, "_req"},    32'(enter_req),   32'h0);
        chk({tag, "_digits"}, 32'(digit_count), 32'h0);
        chk({tag, "_fails"},  32'(fail_count),  32'h0);
        chk({tag, "_lock"},   32'(locked_out),  32'h0);
        chk({tag, "_busy"},   32'(busy),        32'h0);
    endtask

    // Submits a code with the gate held low and lets the 8-cycle window expire.
    task automatic failed_submit(input logic [3:0] hi, input logic [3:0] lo, input int n);
        digit(hi);
        digit(lo);
        enter();
        chk($sformatf("fail%0d_pass", n), 32'(passcode_in), 32'({hi, lo}));
        tick(8);
        chk($sformatf("fail%0d_busy_in_window", n), 32'(busy), 32'h1);
        tick();
        chk($sformatf("fail%0d_count", n), 32'(fail_count), 32'(n));
        chk($sformatf("fail%0d_busy_after", n), 32'(busy), 32'h0);
    endtask

    initial begin
        // Asynchronous reset, checked before any clock edge.
        #2 reset = 1'b1;
        #1 chk_all_zero("reset");
        tick(2);
        reset = 1'b0;
        tick();

        // Accepted code F,F; gate opens 2 cycles after enter_req.
        base = pulses;
        digit(4'hF);
        chk("ff_digit1", 32'(digit_count), 32'd1);
        digit(4'hF);
        chk("ff_digit2", 32'(digit_count), 32'd2);
        chk("ff_ready_pass_zero", 32'(passcode_in), 32'h00);
        enter();
        chk("ff_req", 32'(enter_req), 32'h1);
        chk("ff_req_pass", 32'(passcode_in), 32'hFF);
        chk("ff_req_busy", 32'(busy), 32'h1);
        tick();
        chk("ff_wait_req_low", 32'(enter_req), 32'h0);
        chk("ff_wait_pass", 32'(passcode_in), 32'hFF);
        tick();
        entry_gate_open = 1'b1;
        tick();
        entry_gate_open = 1'b0;
        chk_all_zero("ff_done");
        chk("ff_pulses", 32'(pulses - base), 32'd1);

        // Three rejected submissions lead to lockout.
        base = pulses;
        failed_submit(4'hF, 4'hE, 1);
        failed_submit(4'hF, 4'hE, 2);
        failed_submit(4'hF, 4'hE, 3);
        chk("lock_on", 32'(locked_out), 32'h1);
        digit(4'hF);
        digit(4'hF);
        enter();
        chk("lock_keys_ignored", 32'(digit_count), 32'd0);
        chk("lock_no_req", 32'(enter_req), 32'h0);
        tick(4996);
        chk("lock_last_cycle", 32'(locked_out), 32'h1);
        chk("lock_fails_held", 32'(fail_count), 32'd3);
        tick();
        chk("lock_off", 32'(locked_out), 32'h0);
        chk("lock_fails_clear", 32'(fail_count), 32'd0);
        chk("lock_pulses", 32'(pulses - base), 32'd3);

        // Inactivity timeout after a single digit.
        base = pulses;
        digit(4'hF);
        tick(999);
        chk("timeout_before", 32'(digit_count), 32'd1);
        tick();
        chk("timeout_after", 32'(digit_count), 32'd0);
        enter();
        tick(3);
        chk("timeout_no_req", 32'(pulses - base), 32'd0);

        // Extra digit ignored in READY; accepted on the first window cycle.
        digit(4'h1);
        digit(4'h2);
        digit(4'h3);
        enter();
        chk("ready_extra_pass", 32'(passcode_in), 32'h12);
        entry_gate_open = 1'b1;
        tick(2);
        entry_gate_open = 1'b0;
        chk("ready_extra_done_busy", 32'(busy), 32'h0);

        // Lot full: code discarded, fail_count (1 after one rejection) unchanged.
        failed_submit(4'h5, 4'h6, 1);
        base = pulses;
        digit(4'hF);
        digit(4'hF);
        lot_full = 1'b1;
        enter();
        lot_full = 1'b0;
        chk("full_digits", 32'(digit_count), 32'd0);
        chk("full_fails", 32'(fail_count), 32'd1);
        tick(2);
        chk("full_no_req", 32'(pulses - base), 32'd0);

        // Clear and enter together in READY; clear in DIGIT1; clear beats digit in IDLE.
        digit(4'h1);
        digit(4'h2);
        key_clear = 1'b1;
        key_enter = 1'b1;
        tick();
        key_clear = 1'b0;
        key_enter = 1'b0;
        chk("clr_enter_digits", 32'(digit_count), 32'd0);
        tick(2);
        chk("clr_enter_no_req", 32'(pulses - base), 32'd0);
        digit(4'h3);
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        chk("clr_digit1", 32'(digit_count), 32'd0);
        key_clear = 1'b1;
        key_valid = 1'b1;
        tick();
        key_clear = 1'b0;
        key_valid = 1'b0;
        chk("clr_beats_valid", 32'(digit_count), 32'd0);

        // Reset pulsed during WAIT_RESP.
        base = pulses;
        digit(4'hA);
        digit(4'hB);
        enter();
        tick();
        chk("rst_wait_busy", 32'(busy), 32'h1);
        #2 reset = 1'b1;
        #1 chk_all_zero("rst_mid");
        tick(2);
        reset = 1'b0;
        tick(20);
        chk("rst_one_req_only", 32'(pulses - base), 32'd1);
        chk("rst_fails", 32'(fail_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/parking_keypad_entry.md
PARKING_KEYPAD_ENTRY -- requirements
Module: parking_keypad_entry

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 1000, idle cycles before a partial entry is discarded.
REQ-002 Parameter: RESP_WINDOW, 8, cycles after enter_req within which entry_gate_open signals acceptance.
REQ-003 Parameter: MAX_FAILS, 3, consecutive rejected codes that trigger lockout.
REQ-004 Parameter: LOCKOUT_CYCLES, 5000, lockout duration in cycles.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 key_code  input  4  keypad nibble; sampled only when key_valid=1.
REQ-008 key_valid  input  1  one-cycle strobe; a digit key was pressed.
REQ-009 key_enter  input  1  one-cycle strobe; the submit key was pressed.
REQ-010 key_clear  input  1  one-cycle strobe; the clear key was pressed.
REQ-011 entry_gate_open  input  1  acceptance indication from the parking controller.
REQ-012 lot_full  input  1  lot-full status from the parking controller.
REQ-013 passcode_in  output  8  assembled code presented to the parking controller.
REQ-014 enter_req  output  1  one-cycle entry request to the parking controller.
REQ-015 digit_count  output  2  number of digits held (0..2).
REQ-016 fail_count  output  2  consecutive rejected attempts.
REQ-017 locked_out  output  1  high while in LOCKOUT.
REQ-018 busy  output  1  high in the REQ and WAIT_RESP states.

Function
REQ-019 The FSM SHALL have the states IDLE, DIGIT1, READY, REQ, WAIT_RESP and LOCKOUT.
REQ-020 Same-cycle key priority SHALL be key_clear > key_enter > key_valid; the lower-priority strobes are dropped.
REQ-021 IDLE: key_valid SHALL store key_code as passcode[7:4], set digit_count=1, and move to DIGIT1; key_enter and key_clear SHALL be ignored.
REQ-022 DIGIT1: key_valid SHALL store key_code as passcode[3:0], set digit_count=2, and move to READY; key_enter SHALL be ignored; key_clear SHALL move to IDLE and set digit_count=0.
REQ-023 READY: additional key_valid SHALL be ignored; key_clear SHALL move to IDLE.
REQ-024 READY, key_enter with lot_full=0: SHALL move to REQ.
REQ-025 READY, key_enter with lot_full=1: SHALL discard the code, move to IDLE, and leave fail_count unchanged.
REQ-026 REQ: enter_req SHALL be 1 for exactly one cycle, then the FSM SHALL move to WAIT_RESP.
REQ-027 passcode_in SHALL carry the assembled code in REQ and WAIT_RESP, and SHALL be 8'h00 in every other state.
REQ-028 WAIT_RESP: entry_gate_open=1 on any of the first RESP_WINDOW cycles SHALL clear fail_count, clear digit_count, and move to IDLE.
REQ-029 WAIT_RESP, window expiry: fail_count SHALL increment; if the new value equals MAX_FAILS the FSM SHALL move to LOCKOUT, otherwise to IDLE; digit_count SHALL clear.
REQ-030 All keys SHALL be ignored in REQ, WAIT_RESP and LOCKOUT.
REQ-031 LOCKOUT: locked_out=1 for exactly LOCKOUT_CYCLES cycles; then fail_count=0 and the FSM moves to IDLE.
REQ-032 Inactivity timer, DIGIT1/READY: SHALL restart on every accepted key event.
REQ-033 Inactivity timer reaching TIMEOUT_CYCLES SHALL force IDLE and digit_count=0, with no fail_count change.
REQ-034 Counters SHALL saturate at their terminal value and SHALL never wrap; fail_count SHALL never exceed MAX_FAILS.

Reset
REQ-035 While reset=1, state SHALL be IDLE and all outputs SHALL be 0 (passcode_in=8'h00), effective immediately and independent of clk.
REQ-036 Reset asserted mid-operation (REQ, WAIT_RESP, LOCKOUT) SHALL abort it; no enter_req SHALL be issued after reset release without a new key sequence.

Verification
REQ-037 Keys F,F then enter; entry_gate_open high 2 cycles after enter_req -> one enter_req pulse with passcode_in=8'hFF, fail_count=0, back to IDLE.
REQ-038 Three submissions of F,E with entry_gate_open held 0 -> fail_count 1, 2, then locked_out=1 for 5000 cycles; keys ignored during lockout; afterwards fail_count=0.
REQ-039 Single key F then 1000 idle cycles -> digit_count returns 0; subsequent enter produces no enter_req.
REQ-040 Keys F,F with lot_full=1 at enter -> no enter_req, digit_count=0, fail_count unchanged.
REQ-041 key_clear and key_enter in the same cycle in READY -> IDLE, no enter_req.
REQ-042 Reset pulsed during WAIT_RESP -> all outputs 0 immediately, fail_count=0, no later enter_req.
